// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parameterised LIFO stack with peek, replace and sticky error flags
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst        - synchronous active-high reset
//   clr        - synchronous stack clear (below rst, above push/pop)
//   push, din  - push request and data
//   pop        - pop request
//   dout       - registered popped data, holds until next accepted pop
//   dout_valid - one-cycle pulse per accepted pop
//   top        - combinational peek of the top entry (0 when empty)
//   count      - number of stored entries, 0..DEPTH
//   full/empty - derived from count
//   ovf_err    - sticky: push attempted while full
//   unf_err    - sticky: pop attempted while empty
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] top_ptr;
  logic [DATA_W-1:0] top_val;

  // Low bits of count address the next free slot; when count == DEPTH they
  // wrap to 0, so subtracting one lands on DEPTH-1, the true top.
  assign wr_ptr  = count_q[ADDR_W-1:0];
  assign top_ptr = wr_ptr - ONE_PTR;
  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign top_val = mem_q[top_ptr];
  assign top     = empty ? '0 : top_val;

  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr;

    if (clr) begin
      count_d = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + ONE_CNT;
          end
        end
        2'b01: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d       = top_val;
            dout_valid_d = 1'b1;
            count_d      = count_q - ONE_CNT;
          end
        end
        2'b11: begin
          if (empty) begin
            // Pop half is rejected; push half proceeds into slot 0.
            unf_d   = 1'b1;
            mem_we  = 1'b1;
            count_d = ONE_CNT;
          end else begin
            // Replace: old top goes out, new data overwrites it in place.
            dout_d       = top_val;
            dout_valid_d = 1'b1;
            mem_we       = 1'b1;
            mem_waddr    = top_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Storage has no reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= din;
    end
  end

  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed self-checking bench for lifo_stack
module tb_lifo_stack;

  logic       clk = 1'b0;
  logic       rst, clr, push, pop;
  logic [7:0] din;
  logic [7:0] dout, top;
  logic       dout_valid, full, empty, ovf_err, unf_err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  lifo_stack #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
    .dout(dout), .dout_valid(dout_valid), .top(top), .count(count),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic pu, input logic po, input logic [7:0] d);
    rst = r; clr = c; push = pu; pop = po; din = d;
    @(posedge clk);
    #1;
    rst = 0; clr = 0; push = 0; pop = 0; din = 8'h00;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] c, input logic [7:0] t,
                           input logic [7:0] d, input logic dv, input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".top"},   32'(top),   32'(t));
    chk({tag, ".dout"},  32'(dout),  32'(d));
    chk({tag, ".dv"},    32'(dout_valid), 32'(dv));
    chk({tag, ".ovf"},   32'(ovf_err), 32'(ov));
    chk({tag, ".unf"},   32'(unf_err), 32'(un));
    chk({tag, ".full"},  32'(full),  32'(c == 3'd4));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 3'd0));
  endtask

  initial begin
    rst = 1; clr = 0; push = 0; pop = 0; din = 0;
    step(1, 0, 0, 0, 8'h00);
    chk_state("reset", 3'd0, 8'h00, 8'h00, 0, 0, 0);

    // push three, pop three
    step(0, 0, 1, 0, 8'h11); chk_state("push11", 3'd1, 8'h11, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 8'h22); chk_state("push22", 3'd2, 8'h22, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 8'h33); chk_state("push33", 3'd3, 8'h33, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 8'h00); chk_state("pop1",   3'd2, 8'h22, 8'h33, 1, 0, 0);
    step(0, 0, 0, 1, 8'h00); chk_state("pop2",   3'd1, 8'h11, 8'h22, 1, 0, 0);
    step(0, 0, 0, 1, 8'h00); chk_state("pop3",   3'd0, 8'h00, 8'h11, 1, 0, 0);
    step(0, 0, 0, 0, 8'h00); chk_state("idle_hold", 3'd0, 8'h00, 8'h11, 0, 0, 0);
    // pop on empty: dout holds, underflow sticks
    step(0, 0, 0, 1, 8'h00); chk_state("pop_empty", 3'd0, 8'h00, 8'h11, 0, 0, 1);
    step(0, 1, 0, 0, 8'h00); chk_state("clr1", 3'd0, 8'h00, 8'h00, 0, 0, 0);

    // fill and overflow
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'hA0 + 8'(i));
    chk_state("fill", 3'd4, 8'hA3, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 8'hFF); chk_state("ovf", 3'd4, 8'hA3, 8'h00, 0, 1, 0);
    step(0, 0, 0, 0, 8'h00); chk_state("ovf_sticky", 3'd4, 8'hA3, 8'h00, 0, 1, 0);
    // replace while full
    step(0, 0, 1, 1, 8'h55); chk_state("replace_full", 3'd4, 8'h55, 8'hA3, 1, 1, 0);
    step(0, 0, 0, 1, 8'h00); chk_state("pop_after_rep", 3'd3, 8'hA2, 8'h55, 1, 1, 0);
    step(0, 1, 0, 0, 8'h00); chk_state("clr2", 3'd0, 8'h00, 8'h00, 0, 0, 0);

    // underflow cases
    step(0, 0, 0, 1, 8'h00); chk_state("unf_pop", 3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(0, 0, 1, 1, 8'h7E); chk_state("pushpop_empty", 3'd1, 8'h7E, 8'h00, 0, 0, 1);

    // clr beats push
    step(0, 0, 1, 0, 8'h12); chk_state("push12", 3'd2, 8'h12, 8'h00, 0, 0, 1);
    step(0, 0, 1, 1, 8'h34); chk_state("replace2", 3'd2, 8'h34, 8'h12, 1, 0, 1);
    step(0, 1, 1, 0, 8'h99); chk_state("clr_push", 3'd0, 8'h00, 8'h00, 0, 0, 0);

    // reset beats pop
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, 8'(i));
    chk_state("fill2", 3'd4, 8'h04, 8'h00, 0, 0, 0);
    step(0, 0, 0, 1, 8'h00); chk_state("pop4", 3'd3, 8'h03, 8'h04, 1, 0, 0);
    step(1, 0, 0, 1, 8'h00); chk_state("rst_pop", 3'd0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 8'h5A); chk_state("push_after_rst", 3'd1, 8'h5A, 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the pointer width; DEPTH = 2**ADDR_W entries.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port clr, input, 1, SHALL be the synchronous stack clear.
REQ-006 Port push, input, 1, SHALL be the push request.
REQ-007 Port pop, input, 1, SHALL be the pop request.
REQ-008 Port din, input, DATA_W, SHALL be the push data.
REQ-009 Port dout, output, DATA_W, SHALL be the registered popped data.
REQ-010 Port dout_valid, output, 1, SHALL pulse when dout carries newly popped data.
REQ-011 Port top, output, DATA_W, SHALL be the combinational peek of the top entry.
REQ-012 Port count, output, ADDR_W+1, SHALL be the number of stored entries, range 0..DEPTH.
REQ-013 Port full, output, 1, SHALL be high iff count == DEPTH.
REQ-014 Port empty, output, 1, SHALL be high iff count == 0.
REQ-015 Port ovf_err, output, 1, SHALL be the sticky overflow flag.
REQ-016 Port unf_err, output, 1, SHALL be the sticky underflow flag.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W entries, written only on an accepted push, never cleared by rst or clr.
REQ-018 Priority SHALL be rst > clr > push/pop.
REQ-019 Push only, not full: mem[count] <= din, count +1; top == din the next cycle.
REQ-020 Pop only, not empty: dout <= mem[count-1], count -1, dout_valid = 1 the next cycle.
REQ-021 Push+pop, not empty (including full): replace -- dout <= old top, mem[count-1] <= din, count unchanged, dout_valid = 1, no error flagged.
REQ-022 Push+pop, empty: push accepted (count becomes 1), pop rejected, unf_err set, dout_valid = 0.
REQ-023 Push only while full: ignored (memory and count unchanged), ovf_err set.
REQ-024 Pop only while empty: ignored, unf_err set, dout_valid = 0, dout holds.
REQ-025 dout SHALL hold its value until the next accepted pop; dout_valid SHALL be high for exactly one cycle per accepted pop.
REQ-026 top SHALL equal mem[count-1] when not empty and 0 when empty; no added latency.
REQ-027 ovf_err/unf_err SHALL stay set until rst or clr.
REQ-028 clr SHALL set count = 0, dout = 0, dout_valid = 0, ovf_err = unf_err = 0; push/pop in the same cycle are ignored.
REQ-029 count arithmetic SHALL never wrap: no increment above DEPTH, no decrement below 0.

Reset
REQ-030 On rst high at a rising edge: count = 0, dout = 0, dout_valid = 0, ovf_err = 0, unf_err = 0; hence empty = 1, full = 0, top = 0.
REQ-031 rst asserted during a push or pop SHALL discard the operation; state after that edge equals the reset state.
REQ-032 Outputs SHALL not change between edges except top, count-derived full/empty following the registered count.

Verification (DATA_W=8, ADDR_W=2, DEPTH=4)
REQ-033 Push 0x11,0x22,0x33 on consecutive cycles -> count = 3, top = 0x33; then pop x3 -> dout = 0x33, 0x22, 0x11, dout_valid high each following cycle, empty = 1.
REQ-034 Push 4 values 0xA0..0xA3, then push 0xFF -> full = 1, count = 4, top = 0xA3, ovf_err = 1 and stays 1.
REQ-035 Full stack (top 0xA3), push+pop with din = 0x55 -> dout = 0xA3, dout_valid = 1, count = 4, top = 0x55, no new error.
REQ-036 Empty stack, pop -> unf_err = 1, dout_valid = 0; empty, push+pop with din = 0x7E -> count = 1, top = 0x7E, unf_err = 1.
REQ-037 count = 2 with errors set, assert clr together with push -> count = 0, both errors 0, dout = 0, push ignored.
REQ-038 rst asserted in the same cycle as a pop from count = 3 -> count = 0, dout = 0, dout_valid = 0 after the edge.
